// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states and the
// opcode field location used for halt detection.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;

    localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'b1111;

endpackage

// File: rtl/fetch_ir.sv
// One-entry instruction register with valid/ready output handshake.
// Flush beats load; an unloaded entry empties when the consumer takes it.
module fetch_ir #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller: owns the PC, fills the instruction
// register, and handles redirects, halt draining and resume.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned INSTR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0] HALT_OPCODE  = HALT_OPCODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               resume,
    output logic               halted,
    output logic [31:0]        instr_count
);

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [31:0]     r_count;
    logic            w_load;
    logic            w_flush;
    logic            w_xfer;
    logic            w_is_halt;
    logic            w_if_valid;

    assign w_xfer    = w_if_valid && id_ready;
    assign w_is_halt = (instruction[OPC_HI:OPC_LO] == HALT_OPCODE);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN: begin
                if (!w_if_valid || id_ready) begin
                    w_load = 1'b1;
                    // A halt word parks the PC on itself until resume.
                    if (w_is_halt) w_state_next = S_DRAIN;
                    else           w_pc_next    = r_pc + PC_W'(1);
                end
            end
            S_DRAIN: if (w_xfer) w_state_next = S_HALT;
            S_HALT: begin
                if (resume) begin
                    w_pc_next    = r_pc + PC_W'(1);
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
        if (redirect_valid && r_state != S_BOOT) begin
            w_pc_next    = redirect_pc;
            w_load       = 1'b0;
            w_flush      = 1'b1;
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_xfer) r_count <= r_count + 32'd1;
        end
    end

    fetch_ir #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ir (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ready (id_ready),
        .i_instr (instruction),
        .i_pc    (r_pc),
        .o_valid (w_if_valid),
        .o_instr (if_instr),
        .o_pc    (if_pc)
    );

    assign pc          = r_pc;
    assign if_valid    = w_if_valid;
    assign halted      = (r_state == S_HALT);
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer against a cycle-level
// reference model of fetch, halt, resume and redirect behaviour.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [15:0] instruction;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        resume = 1'b0;
    logic        halted;
    logic [31:0] instr_count;

    logic [15:0] mem [256];

    // Reference model state
    logic [31:0] m_pc = '0;
    logic [31:0] m_ipc = '0;
    logic [31:0] m_count = '0;
    logic [15:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_boot = 1'b1;
    bit          m_drain = 1'b0;
    bit          m_halted = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign instruction = mem[pc[7:0]];

    fetch_sequencer #(
        .PC_W        (32),
        .INSTR_W     (16),
        .RESET_PC    (32'd0),
        .HALT_OPCODE (4'b1111)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .instruction    (instruction),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from the inputs now applied, then compare.
    task automatic step();
        logic [31:0] n_pc, n_ipc, n_count;
        logic [15:0] n_instr;
        bit n_valid, n_boot, n_drain, n_halted, xfer;
        n_pc = m_pc; n_ipc = m_ipc; n_count = m_count; n_instr = m_instr;
        n_valid = m_valid; n_boot = m_boot; n_drain = m_drain; n_halted = m_halted;
        if (rst) begin
            n_pc = '0; n_ipc = '0; n_count = '0; n_instr = '0;
            n_valid = 0; n_boot = 1; n_drain = 0; n_halted = 0;
        end else begin
            xfer = m_valid && id_ready;
            if (xfer) n_count = m_count + 1;
            if (m_boot) begin
                n_boot = 0;
            end else if (redirect_valid) begin
                n_pc = redirect_pc; n_valid = 0; n_drain = 0; n_halted = 0;
            end else if (m_halted) begin
                if (resume) begin
                    n_pc = m_pc + 1; n_halted = 0;
                end
            end else if (m_drain) begin
                if (xfer) begin
                    n_valid = 0; n_drain = 0; n_halted = 1;
                end
            end else if (!m_valid || id_ready) begin
                n_instr = mem[m_pc[7:0]];
                n_ipc = m_pc;
                n_valid = 1;
                if (n_instr[15:12] == 4'hF) n_drain = 1;
                else n_pc = m_pc + 1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ipc = n_ipc; m_count = n_count; m_instr = n_instr;
        m_valid = n_valid; m_boot = n_boot; m_drain = n_drain; m_halted = n_halted;
        chk("pc", pc, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("if_instr", {16'd0, if_instr}, {16'd0, m_instr});
            chk("if_pc", if_pc, m_ipc);
        end
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("instr_count", instr_count, m_count);
        redirect_valid = 1'b0;
        resume = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"}, {16'd0, if_instr}, 32'd0);
        chk({tag, "_ifpc"}, if_pc, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_count"}, instr_count, 32'd0);
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 40 && !m_halted; i++) step();
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
        mem[3] = 16'h4567; mem[4] = 16'h5678; mem[5] = 16'hF000;

        // Reset, redirect ignored during boot, straight-line fetch
        rst = 1'b1;
        step(); step();
        chk_reset_vals("rst0");
        rst = 1'b0; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'd77;
        step();
        chk("boot_redir_ignored", pc, 32'd0);
        step();
        chk("sl_first_instr", {16'd0, if_instr}, 32'h1234);
        chk("sl_first_pc", if_pc, 32'd0);
        repeat (4) step();
        chk("sl_count", instr_count, 32'd4);

        // Backpressure
        rst = 1'b1; step(); rst = 1'b0;
        step();
        id_ready = 1'b0;
        step();
        repeat (3) step();
        chk("bp_held", {16'd0, if_instr}, 32'h1234);
        chk("bp_pc_frozen", pc, 32'd1);
        id_ready = 1'b1;
        step();
        chk("bp_release", {16'd0, if_instr}, 32'h2345);

        // Redirect while pc 2 is being consumed
        for (int i = 0; i < 10 && !(m_valid && m_ipc == 32'd2); i++) step();
        chk("rd_at_pc2", if_pc, 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        step();
        chk("rd_flush", {31'd0, if_valid}, 32'd0);
        chk("rd_pc", pc, 32'd8);
        chk("rd_count", instr_count, 32'd3);
        step();
        chk("rd_target", if_pc, 32'd8);

        // Halt and resume
        redirect_valid = 1'b1; redirect_pc = 32'd4;
        step();
        run_to_halt("halt_reached");
        chk("halt_pc", pc, 32'd5);
        repeat (2) step();
        resume = 1'b1;
        step();
        chk("resume_pc", pc, 32'd6);
        step();
        chk("resume_fetch", if_pc, 32'd6);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        step();
        chk("wrap_ifpc", if_pc, 32'hFFFF_FFFF);
        chk("wrap_pc", pc, 32'd0);

        // Redirect and resume together in halt
        redirect_valid = 1'b1; redirect_pc = 32'd5;
        step();
        run_to_halt("halt2_reached");
        redirect_valid = 1'b1; redirect_pc = 32'd20; resume = 1'b1;
        step();
        chk("conflict_pc", pc, 32'd20);
        step();
        chk("conflict_fetch", if_pc, 32'd20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) resume = 1'b1;
            step();
        end

        // Reset mid-run with a valid instruction held
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd1;
        step();
        for (int i = 0; i < 5 && !m_valid; i++) step();
        chk("mid_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        rst = 1'b0; id_ready = 1'b1;
        step(); step();
        chk("restart_pc", if_pc, 32'd0);
        chk("restart_instr", {16'd0, if_instr}, 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
